// File: rtl/ddram_arb_pkg.sv
// Types and constants shared by the two-client DDRAM arbiter.
package ddram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;
    typedef enum logic {OWN_C0, OWN_C1} owner_t;

    localparam int DDR_DW  = 64;
    localparam int DDR_BEW = 8;
    localparam logic [DDR_BEW-1:0] BE_ALL = '1;

endpackage

// File: rtl/ddram_arbiter.sv
// Shares the DDRAM port between a burst-read video client (c0, priority) and a
// single-beat CPU/loader client (c1), with a starvation guard for c1.
module ddram_arbiter
    import ddram_arb_pkg::*;
#(
    parameter int AW           = 29,
    parameter int BW           = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               c0_req,
    input  logic [AW-1:0]      c0_addr,
    input  logic [BW-1:0]      c0_burst,
    output logic [DDR_DW-1:0]  c0_rdata,
    output logic               c0_rvalid,
    output logic               c0_done,

    input  logic               c1_req,
    input  logic               c1_we,
    input  logic [AW-1:0]      c1_addr,
    input  logic [DDR_DW-1:0]  c1_wdata,
    input  logic [DDR_BEW-1:0] c1_be,
    output logic [DDR_DW-1:0]  c1_rdata,
    output logic               c1_done,

    input  logic               ddram_busy,
    input  logic [DDR_DW-1:0]  ddram_dout,
    input  logic               ddram_dout_rdy,
    output logic [7:0]         ddram_burstcnt,
    output logic [AW-1:0]      ddram_addr,
    output logic               ddram_rd,
    output logic               ddram_we,
    output logic [DDR_DW-1:0]  ddram_din,
    output logic [DDR_BEW-1:0] ddram_be
);

    localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [BW-1:0] ONE_BEAT   = BW'(1);

    state_t               state_reg, state_next;
    owner_t               owner_reg;
    logic [3:0]           starve_cnt_reg;
    logic [BW-1:0]        beat_cnt_reg;
    logic [BW-1:0]        burst_reg;
    logic                 rd_reg, we_reg;
    logic [AW-1:0]        addr_reg;
    logic [DDR_DW-1:0]    din_reg;
    logic [DDR_BEW-1:0]   be_reg;
    logic [DDR_DW-1:0]    c0_rdata_reg, c1_rdata_reg;
    logic                 c0_rvalid_reg, c0_done_reg, c1_done_reg;

    logic                 grant_c0, grant_c1, beat;
    logic [BW-1:0]        c0_burst_norm;

    assign c0_burst_norm = (c0_burst == '0) ? ONE_BEAT : c0_burst;
    assign beat          = (state_reg == RDWAIT) && ddram_dout_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // done is registered, so it is visible while the FSM is already back in
    // IDLE; requests are not sampled in that cycle to avoid a double grant.
    always_comb begin
        state_next = state_reg;
        grant_c0   = 1'b0;
        grant_c1   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!c0_done_reg && !c1_done_reg) begin
                    if (c1_req && (!c0_req || starve_cnt_reg == STARVE_MAX)) begin
                        grant_c1 = 1'b1;
                    end else if (c0_req) begin
                        grant_c0 = 1'b1;
                    end
                end
                if (grant_c0 || grant_c1) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!ddram_busy) begin
                    state_next = we_reg ? DONE : RDWAIT;
                end
            end
            RDWAIT: begin
                if (beat && beat_cnt_reg == ONE_BEAT) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_reg      <= OWN_C0;
            starve_cnt_reg <= '0;
            beat_cnt_reg   <= '0;
            burst_reg      <= '0;
            rd_reg         <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            din_reg        <= '0;
            be_reg         <= '0;
            c0_rdata_reg   <= '0;
            c0_rvalid_reg  <= 1'b0;
            c0_done_reg    <= 1'b0;
            c1_rdata_reg   <= '0;
            c1_done_reg    <= 1'b0;
        end else begin
            if (grant_c0) begin
                owner_reg    <= OWN_C0;
                rd_reg       <= 1'b1;
                we_reg       <= 1'b0;
                addr_reg     <= c0_addr;
                burst_reg    <= c0_burst_norm;
                beat_cnt_reg <= c0_burst_norm;
                din_reg      <= '0;
                be_reg       <= BE_ALL;
            end else if (grant_c1) begin
                owner_reg    <= OWN_C1;
                rd_reg       <= !c1_we;
                we_reg       <= c1_we;
                addr_reg     <= c1_addr;
                burst_reg    <= ONE_BEAT;
                beat_cnt_reg <= ONE_BEAT;
                din_reg      <= c1_wdata;
                be_reg       <= c1_be;
            end else if (state_reg == ISSUE && !ddram_busy) begin
                rd_reg <= 1'b0;
                we_reg <= 1'b0;
            end else if (beat) begin
                beat_cnt_reg <= beat_cnt_reg - ONE_BEAT;
            end

            if (grant_c1) begin
                starve_cnt_reg <= '0;
            end else if (grant_c0 && c1_req) begin
                if (starve_cnt_reg != STARVE_MAX) begin
                    starve_cnt_reg <= starve_cnt_reg + 4'd1;
                end
            end else if (state_reg == IDLE && !c1_req) begin
                starve_cnt_reg <= '0;
            end

            c0_rvalid_reg <= beat && (owner_reg == OWN_C0);
            if (beat && owner_reg == OWN_C0) begin
                c0_rdata_reg <= ddram_dout;
            end
            if (beat && owner_reg == OWN_C1) begin
                c1_rdata_reg <= ddram_dout;
            end

            c0_done_reg <= (state_reg == DONE) && (owner_reg == OWN_C0);
            c1_done_reg <= (state_reg == DONE) && (owner_reg == OWN_C1);
        end
    end

    assign c0_rdata       = c0_rdata_reg;
    assign c0_rvalid      = c0_rvalid_reg;
    assign c0_done        = c0_done_reg;
    assign c1_rdata       = c1_rdata_reg;
    assign c1_done        = c1_done_reg;
    assign ddram_burstcnt = 8'(burst_reg);
    assign ddram_addr     = addr_reg;
    assign ddram_rd       = rd_reg;
    assign ddram_we       = we_reg;
    assign ddram_din      = din_reg;
    assign ddram_be       = be_reg;

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: a DDRAM responder with a reference model checked every
// cycle, plus directed scenarios with hand-computed latencies and values.
`timescale 1ns/1ps
module tb_ddram_arbiter;

    localparam int AW    = 29;
    localparam int BW    = 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          c0_req;
    logic [AW-1:0] c0_addr;
    logic [BW-1:0] c0_burst;
    logic [63:0]   c0_rdata;
    logic          c0_rvalid, c0_done;
    logic          c1_req, c1_we;
    logic [AW-1:0] c1_addr;
    logic [63:0]   c1_wdata;
    logic [7:0]    c1_be;
    logic [63:0]   c1_rdata;
    logic          c1_done;
    logic          ddram_busy;
    logic [63:0]   ddram_dout;
    logic          ddram_dout_rdy;
    logic [7:0]    ddram_burstcnt;
    logic [AW-1:0] ddram_addr;
    logic          ddram_rd, ddram_we;
    logic [63:0]   ddram_din;
    logic [7:0]    ddram_be;

    int vectors = 0;
    int miscompares = 0;

    int busy_cfg = 0;
    int rd_lat   = 0;
    bit stray_en = 1'b0;

    int rd_cycles = 0, we_cycles = 0, rv_count = 0, c0_dones = 0, c1_dones = 0;
    int rd_base, we_base, rv_base, c0d_base, c1d_base;

    int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    ddram_arbiter #(.AW(AW), .BW(BW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_burst(c0_burst),
        .c0_rdata(c0_rdata), .c0_rvalid(c0_rvalid), .c0_done(c0_done),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_be(c1_be), .c1_rdata(c1_rdata), .c1_done(c1_done),
        .ddram_busy(ddram_busy), .ddram_dout(ddram_dout), .ddram_dout_rdy(ddram_dout_rdy),
        .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr), .ddram_rd(ddram_rd),
        .ddram_we(ddram_we), .ddram_din(ddram_din), .ddram_be(ddram_be)
    );

    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {32'(a) | 32'hA000_0000, 32'(a) ^ 32'h5A5A_5A5A};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] out_activity();
        return {ddram_rd, ddram_we, c0_rvalid, c0_done, c1_done, |ddram_addr,
                |ddram_burstcnt, |ddram_din, |ddram_be, |c0_rdata, |c1_rdata};
    endfunction

    // Reference model and DDRAM responder, evaluated at every falling edge.
    int          cyc = 0;
    bit          cur_active, cur_acc, cur_owner, bench_idle;
    bit          prev_c0_req, prev_c1_req;
    int          starve, busy_left, beats_left, lat_left, beat_idx;
    int          done_c0_at, done_c1_at;
    bit          exp_rv;
    logic [63:0] exp_rdata, exp_c1, exp_c1_next;
    bit          e_rd, e_we;
    logic [AW-1:0] e_addr;
    logic [7:0]  e_bc, e_be;
    logic [63:0] e_din;

    task automatic model_reset();
        cur_active = 0; cur_acc = 0; bench_idle = 1; starve = 0;
        busy_left = 0; beats_left = 0; lat_left = 0; beat_idx = 0;
        done_c0_at = -1; done_c1_at = -1;
        exp_rv = 0; exp_rdata = '0; exp_c1 = '0; exp_c1_next = '0;
        ddram_busy = 1'b0; ddram_dout_rdy = 1'b0; ddram_dout = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("reset_outputs", 64'(out_activity()), 64'd0);
                model_reset();
            end else begin
                exp_c1 = exp_c1_next;
                check("c0_rvalid", 64'(c0_rvalid), 64'(exp_rv));
                if (exp_rv) check("c0_rdata", c0_rdata, exp_rdata);
                check("c0_done", 64'(c0_done), 64'(cyc == done_c0_at));
                check("c1_done", 64'(c1_done), 64'(cyc == done_c1_at));
                check("c1_rdata", c1_rdata, exp_c1);
                rd_cycles += int'(ddram_rd);
                we_cycles += int'(ddram_we);
                rv_count  += int'(c0_rvalid);
                c0_dones  += int'(c0_done);
                c1_dones  += int'(c1_done);
                if (cyc == done_c0_at || cyc == done_c1_at) begin
                    cur_active = 0;
                    bench_idle = 1;
                end

                // read beats, after the configured latency
                exp_rv = 0;
                ddram_dout_rdy = 1'b0;
                if (beats_left > 0) begin
                    if (lat_left > 0) begin
                        lat_left--;
                    end else begin
                        ddram_dout_rdy = 1'b1;
                        ddram_dout = mem_word(e_addr + AW'(beat_idx));
                        if (!cur_owner) begin
                            exp_rv = 1;
                            exp_rdata = ddram_dout;
                        end else begin
                            exp_c1_next = ddram_dout;
                        end
                        beat_idx++;
                        beats_left--;
                        if (beats_left == 0) begin
                            if (cur_owner) done_c1_at = cyc + 2;
                            else           done_c0_at = cyc + 2;
                        end
                    end
                end else if (stray_en) begin
                    ddram_dout_rdy = 1'b1;
                    ddram_dout = {$urandom, $urandom};
                end

                // command side: arbitration decision and field checks
                ddram_busy = 1'b0;
                if (ddram_rd || ddram_we) begin
                    if (!cur_active) begin
                        check("grant_has_req", 64'(prev_c0_req | prev_c1_req), 64'd1);
                        cur_owner = prev_c1_req && (!prev_c0_req || starve == LIMIT);
                        if (cur_owner) begin
                            e_rd = !c1_we; e_we = c1_we; e_addr = c1_addr;
                            e_bc = 8'd1; e_din = c1_wdata; e_be = c1_be;
                            starve = 0;
                        end else begin
                            e_rd = 1; e_we = 0; e_addr = c0_addr;
                            e_bc = (c0_burst == '0) ? 8'd1 : 8'(c0_burst);
                            e_din = '0; e_be = 8'hFF;
                            if (prev_c1_req && starve < LIMIT) starve++;
                        end
                        cur_active = 1; cur_acc = 0; bench_idle = 0;
                        busy_left = busy_cfg;
                    end
                    if (cur_acc) begin
                        check("cmd_after_accept", 64'(ddram_rd | ddram_we), 64'd0);
                    end else begin
                        check("cmd_rd", 64'(ddram_rd), 64'(e_rd));
                        check("cmd_we", 64'(ddram_we), 64'(e_we));
                        check("cmd_addr", 64'(ddram_addr), 64'(e_addr));
                        check("cmd_burstcnt", 64'(ddram_burstcnt), 64'(e_bc));
                        check("cmd_be", 64'(ddram_be), 64'(e_be));
                        if (e_we) check("cmd_din", ddram_din, e_din);
                        if (busy_left > 0) begin
                            ddram_busy = 1'b1;
                            busy_left--;
                        end else begin
                            cur_acc = 1;
                            if (e_we) begin
                                done_c1_at = cyc + 2;
                            end else begin
                                beats_left = e_bc;
                                lat_left = rd_lat;
                                beat_idx = 0;
                            end
                        end
                    end
                end

                if (bench_idle && !c1_req) starve = 0;
                prev_c0_req = c0_req;
                prev_c1_req = c1_req;
                cyc++;
            end
        end
    end

    task automatic snap();
        rd_base = rd_cycles; we_base = we_cycles; rv_base = rv_count;
        c0d_base = c0_dones; c1d_base = c1_dones;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit who, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(who ? c1_done : c0_done) && n < budget);
        check(who ? "done_timeout_c1" : "done_timeout_c0", 64'(who ? c1_done : c0_done), 64'd1);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rv_seen;
        int got[$];

        reset_n = 1'b0; c0_req = 0; c0_addr = '0; c0_burst = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0; c1_be = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: c0 burst of 4 at 0x100
        snap();
        c0_addr = 'h100; c0_burst = 4; c0_req = 1;
        wait_done(0, 60, n);
        c0_req = 0;
        check("t1_latency", 64'(n), 64'd7);
        settle();
        check("t1_rd_pulses", 64'(rd_cycles - rd_base), 64'd1);
        check("t1_rvalids", 64'(rv_count - rv_base), 64'd4);
        check("t1_dones", 64'(c0_dones - c0d_base), 64'd1);
        $display("t1: c0 read 4 beats, latency %0d", n);

        // 2: c1 write held off by 5 busy cycles
        snap();
        busy_cfg = 5;
        c1_we = 1; c1_addr = 'h20; c1_wdata = 64'hDEADBEEF_CAFEF00D; c1_be = 8'h0F; c1_req = 1;
        wait_done(1, 60, n);
        c1_req = 0;
        busy_cfg = 0;
        check("t2_latency", 64'(n), 64'd8);
        settle();
        check("t2_we_cycles", 64'(we_cycles - we_base), 64'd6);
        check("t2_c1_dones", 64'(c1_dones - c1d_base), 64'd1);
        check("t2_no_read", 64'(rd_cycles - rd_base), 64'd0);
        $display("t2: c1 write under busy, latency %0d", n);

        // 3: both clients requesting continuously
        c0_addr = 'h200; c0_burst = 2;
        c1_we = 1; c1_addr = 'h30; c1_wdata = 64'h0123_4567_89AB_CDEF; c1_be = 8'hFF;
        c0_req = 1; c1_req = 1;
        n = 0;
        while (got.size() < 10 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (c0_done) got.push_back(0);
            if (c1_done) got.push_back(1);
        end
        c0_req = 0; c1_req = 0;
        check("t3_grant_count", 64'(got.size()), 64'd10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            check($sformatf("t3_grant%0d", i), 64'(got[i]), 64'(exp_order[i]));
        end
        $display("t3: %0d grants observed under contention", got.size());
        settle();

        // 4: burst length 0 is a single beat
        snap();
        c0_addr = 'h300; c0_burst = 0; c0_req = 1;
        wait_done(0, 60, n);
        c0_req = 0;
        check("t4_latency", 64'(n), 64'd4);
        settle();
        check("t4_rvalids", 64'(rv_count - rv_base), 64'd1);
        check("t4_rd_pulses", 64'(rd_cycles - rd_base), 64'd1);
        $display("t4: zero burst read, latency %0d", n);

        // 5: stray dout_rdy while idle, then reset mid-burst
        snap();
        stray_en = 1;
        repeat (4) @(posedge clk);
        #1;
        stray_en = 0;
        settle();
        check("t5_stray_rvalid", 64'(rv_count - rv_base), 64'd0);
        check("t5_stray_done", 64'((c0_dones - c0d_base) + (c1_dones - c1d_base)), 64'd0);
        check("t5_stray_cmd", 64'(rd_cycles - rd_base), 64'd0);
        c0_addr = 'h400; c0_burst = 8; c0_req = 1;
        rv_seen = 0; n = 0;
        while (rv_seen < 2 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            rv_seen += int'(c0_rvalid);
        end
        check("t5_reached_beat2", 64'(rv_seen), 64'd2);
        reset_n = 1'b0;
        c0_req = 0;
        #1;
        check("t5_async_reset", 64'(out_activity()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        snap();
        c0_addr = 'h500; c0_burst = 2; c0_req = 1;
        wait_done(0, 60, n);
        c0_req = 0;
        check("t5_after_reset_latency", 64'(n), 64'd5);
        settle();
        check("t5_after_reset_rvalids", 64'(rv_count - rv_base), 64'd2);
        $display("t5: stray beats ignored, reset mid-burst recovered");

        // 6: c1 read with 3 cycles of DDRAM latency
        rd_lat = 3;
        c1_we = 0; c1_addr = 'h55; c1_req = 1;
        wait_done(1, 60, n);
        c1_req = 0;
        check("t6_latency", 64'(n), 64'd7);
        check("t6_rdata", c1_rdata, 64'hA0000055_5A5A5A0F);
        rd_lat = 0;
        settle();
        c0_addr = 'h600; c0_burst = 1; c0_req = 1;
        wait_done(0, 60, n);
        c0_req = 0;
        settle();
        check("t6_rdata_held", c1_rdata, 64'hA0000055_5A5A5A0F);
        $display("t6: c1 read data %h", c1_rdata);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
